fpu_writeback: RTL and testbench
================================

Name: fpu_writeback

Overview:
- Stage directly downstream of the FPU.
- Pairs each FPU result with its destination register tag, which is pushed in issue order when the FPU accepts an op.
- Holds the result in a one-entry output register with valid/ready handshake toward the FP register file.
- Accumulates sticky exception flags (fflags) for the CSR unit.

Parameters:
TAG_DEPTH, 2, number of entries in the in-order rd-tag FIFO (power of two, >= 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
flush  input  1  synchronous pipeline flush
issue_valid  input  1  push rd tag; asserted in the same cycle the FPU handshake (valid_in && ready_out) fires
issue_rd  input  5  destination FP register of the issued op
issue_ready  output  1  tag FIFO not full
fpu_valid  input  1  FPU result valid
fpu_ready  output  1  this stage accepts FPU result
fpu_y  input  32  FPU result
fpu_IV  input  1  invalid flag
fpu_DZ  input  1  divide-by-zero flag
fpu_OF  input  1  overflow flag
fpu_UF  input  1  underflow flag
fpu_IE  input  1  inexact flag
wb_valid  output  1  writeback valid
wb_ready  input  1  register file accepts writeback
wb_rd  output  5  writeback register index
wb_data  output  32  writeback data
fflags  output  5  sticky flags {NV,DZ,OF,UF,NX}
csr_we  input  1  CSR write to fflags
csr_wdata  input  5  CSR write data

Behaviour:
Clock and reset:
- Single clock clk.
- reset is synchronous and active-high.
- flush is synchronous.

Reset values:
- wb_valid=0, wb_rd=0, wb_data=0, fflags=0.
- Tag FIFO empty: issue_ready=1, fpu_ready=0.

Tag FIFO:
- Circular buffer of TAG_DEPTH entries with read/write pointers that wrap modulo TAG_DEPTH, and a count of width clog2(TAG_DEPTH)+1.
- Push when issue_valid && issue_ready.
- Pop when the FPU result is accepted.
- issue_ready = count != TAG_DEPTH. A same-cycle pop does not free space for a push when full.
- Push and pop in the same cycle when 0 < count < TAG_DEPTH: count unchanged, both pointers advance.
- No bypass: a tag pushed in cycle N is usable for a result at cycle N+1 at the earliest.
- issue_valid while full is a protocol error. The push is dropped; an assertion flags it.

Result acceptance:
- fpu_ready = (count != 0) && (!wb_valid || wb_ready). This is combinational and may depend on wb_ready.
- accept = fpu_valid && fpu_ready.
- On accept, next cycle: wb_valid=1, wb_data=fpu_y, wb_rd=FIFO head, and the head is popped.
- Latency is 1 cycle from accept to wb_valid.
- Back-to-back: with wb_ready held at 1, one result is written back per cycle.

Output register:
- When wb_valid && wb_ready && !accept: wb_valid=0. wb_rd and wb_data hold their values.
- wb_data and wb_rd stay stable while wb_valid && !wb_ready.

fflags:
- new = {fpu_IV,fpu_DZ,fpu_OF,fpu_UF,fpu_IE} when accept, else 0.
- Next value: (csr_we ? csr_wdata : fflags) | new.
- A CSR write takes priority, but flags from a result accepted in the same cycle are still ORed in.
- fflags update at accept, not at writeback.

Flush:
- Empties the FIFO and clears wb_valid.
- fpu_ready is forced to 0 in the flush cycle.
- fflags are not affected by flush, except by a csr_we in the same cycle.
- Flush has priority over push and accept in the same cycle.

Reset mid-operation:
- All state returns to reset values the next cycle.
- An in-flight FPU result is discarded.

Test Plan:
- Reset, push rd=5, FPU returns y=0x3F800000 with IE=1, wb_ready=1 -> one cycle after accept: wb_valid=1, wb_rd=5, wb_data=0x3F800000; fflags=5'b00001; FIFO empty.
- Push rd=1 and rd=2; two results 0x40000000 then 0x40400000 with wb_ready=0 -> first held at wb_rd=1; fpu_ready=0 while stalled. Release wb_ready -> writebacks in order (1, 0x40000000) then (2, 0x40400000).
- TAG_DEPTH=2, push 2 tags without results -> issue_ready=0. Pop one -> issue_ready=1 next cycle. Continuous push/pop run over 8 ops -> pointers wrap, order preserved.
- fflags=5'b00001; same cycle: csr_we=1, csr_wdata=0, accepted result with DZ=1 -> fflags=5'b01000.
- FIFO holds 1 tag and wb_valid=1; assert flush -> next cycle wb_valid=0, issue_ready=1, fpu_ready=0; fflags unchanged.
- Mid-stall reset with wb_valid=1 and 2 tags queued -> next cycle all outputs at reset values, fflags=0.

Source files
------------

// File: rtl/fpu_writeback.sv
// FPU writeback stage: pairs each FPU result with its in-order destination
// tag, presents it to the FP register file through a one-entry output
// register with a valid/ready handshake, and accumulates sticky fflags.
module fpu_writeback #(
    parameter int TAG_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic        fpu_valid,
    output logic        fpu_ready,
    input  logic [31:0] fpu_y,
    input  logic        fpu_IV,
    input  logic        fpu_DZ,
    input  logic        fpu_OF,
    input  logic        fpu_UF,
    input  logic        fpu_IE,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  fflags,
    input  logic        csr_we,
    input  logic [4:0]  csr_wdata
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    tag_q [TAG_DEPTH];

    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [4:0]    fflags_q, fflags_d;

    logic          push;
    logic          accept;
    logic [4:0]    head_rd;
    logic [4:0]    new_flags;

    // Handshake decode; flush masks both push and accept so nothing enters
    // the stage in the cycle that empties it.
    always_comb begin
        issue_ready = (count_q != CW'(TAG_DEPTH));
        fpu_ready   = !flush && (count_q != '0) && (!wb_valid_q || wb_ready);
        accept      = fpu_valid && fpu_ready;
        push        = issue_valid && issue_ready && !flush;
        head_rd     = tag_q[rd_ptr_q];
        new_flags   = accept ? {fpu_IV, fpu_DZ, fpu_OF, fpu_UF, fpu_IE} : 5'b0;
    end

    // Tag FIFO pointer/count next state; pointers wrap naturally since the
    // depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
            if (accept) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(accept);
        end
    end

    // Output register and sticky-flag next state.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (accept) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = head_rd;
            wb_data_d  = fpu_y;
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end
        // A CSR write wins over the held value, but flags of a result
        // accepted in the same cycle must not be lost.
        fflags_d = (csr_we ? csr_wdata : fflags_q) | new_flags;
    end

    // Tag storage, one register per entry; a tag written this cycle is only
    // visible at the head from the next cycle on (no bypass).
    generate
        for (genvar gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_q[gi] <= '0;
                end else if (push && (wr_ptr_q == PW'(gi))) begin
                    tag_q[gi] <= issue_rd;
                end
            end
        end
    endgenerate

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fflags_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fflags_q   <= fflags_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign fflags   = fflags_q;

    // Issuing into a full tag FIFO is a protocol error; the tag is dropped.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset || flush)
        !(issue_valid && !issue_ready));

endmodule

// File: tb/tb_fpu_writeback.sv
// Directed bench for fpu_writeback with a scoreboard of expected writebacks.
module tb_fpu_writeback;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        fpu_valid, fpu_ready;
    logic [31:0] fpu_y;
    logic        fpu_IV, fpu_DZ, fpu_OF, fpu_UF, fpu_IE;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  fflags;
    logic        csr_we;
    logic [4:0]  csr_wdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    fpu_writeback #(.TAG_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_y(fpu_y),
        .fpu_IV(fpu_IV), .fpu_DZ(fpu_DZ), .fpu_OF(fpu_OF), .fpu_UF(fpu_UF), .fpu_IE(fpu_IE),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .fflags(fflags), .csr_we(csr_we), .csr_wdata(csr_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every handshake toward the register file is checked in order.
    always @(negedge clk) begin
        if (!reset && !flush && wb_valid && wb_ready) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected observed rd=%0d data=%h expected none", wb_rd, wb_data);
            end else begin
                e = sb_q.pop_front();
                assert (wb_rd === e.rd && wb_data === e.data) else begin
                    failures++;
                    $error("FAIL wb_order observed rd=%0d data=%h expected rd=%0d data=%h",
                           wb_rd, wb_data, e.rd, e.data);
                end
                $display("wb rd=%0d data=%h", wb_rd, wb_data);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
        fpu_valid = 1'b0; fpu_y = '0; fpu_IV = 0; fpu_DZ = 0; fpu_OF = 0; fpu_UF = 0; fpu_IE = 0;
        wb_ready = 1'b0; csr_we = 1'b0; csr_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fflags", fflags, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_fpu_ready", fpu_ready, 0);

        // Single op with inexact flag
        wb_ready = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        fpu_valid = 1'b1; fpu_y = 32'h3F80_0000; fpu_IE = 1'b1;
        expect_wb(5'd5, 32'h3F80_0000);
        #1 check("t1_fpu_ready", fpu_ready, 1);
        tick();
        fpu_valid = 1'b0; fpu_IE = 1'b0;
        #1;
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_rd", wb_rd, 5);
        check("t1_wb_data", wb_data, 32'h3F80_0000);
        check("t1_fflags", fflags, 5'b00001);
        check("t1_fifo_empty", fpu_ready, 0);
        tick();
        check("t1_wb_drain", wb_valid, 0);

        // Stall with register file not ready
        wb_ready = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd1;
        tick();
        issue_rd = 5'd2;
        tick();
        issue_valid = 1'b0;
        #1 check("t2_full", issue_ready, 0);
        fpu_valid = 1'b1; fpu_y = 32'h4000_0000;
        expect_wb(5'd1, 32'h4000_0000);
        #1 check("t2_fpu_ready", fpu_ready, 1);
        tick();
        fpu_y = 32'h4040_0000;
        #1;
        check("t2_wb_valid", wb_valid, 1);
        check("t2_wb_rd", wb_rd, 1);
        check("t2_stall_ready", fpu_ready, 0);
        check("t2_one_free", issue_ready, 1);
        tick();
        check("t2_hold_rd", wb_rd, 1);
        check("t2_hold_data", wb_data, 32'h4000_0000);
        wb_ready = 1'b1;
        expect_wb(5'd2, 32'h4040_0000);
        #1 check("t2_release_ready", fpu_ready, 1);
        tick();
        fpu_valid = 1'b0;
        #1 check("t2_second_rd", wb_rd, 2);
        tick();
        check("t2_drain", wb_valid, 0);

        // Continuous push/pop over 8 ops, wrapping the pointers
        for (int i = 0; i <= 8; i++) begin
            issue_valid = (i < 8);
            issue_rd    = 5'(10 + i);
            fpu_valid   = (i > 0);
            fpu_y       = 32'h1000_0000 + 32'(i);
            fpu_OF      = (i == 4);
            if (i > 0) begin
                expect_wb(5'(10 + i - 1), 32'h1000_0000 + 32'(i));
                #1 check("t3_stream_ready", fpu_ready, 1);
            end
            tick();
        end
        issue_valid = 1'b0; fpu_valid = 1'b0; fpu_OF = 1'b0;
        tick();
        check("t3_fflags", fflags, 5'b00101);

        // Fill, pop one, then flush with a result pending
        wb_ready = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd20;
        tick();
        issue_rd = 5'd21;
        tick();
        issue_valid = 1'b0;
        #1 check("t5_full", issue_ready, 0);
        fpu_valid = 1'b1; fpu_y = 32'hDEAD_BEEF;
        tick();
        fpu_valid = 1'b0;
        #1;
        check("t5_pop_frees", issue_ready, 1);
        check("t5_wb_valid", wb_valid, 1);
        flush = 1'b1; wb_ready = 1'b1; fpu_valid = 1'b1; fpu_IV = 1'b1;
        #1 check("t5_flush_fpu_ready", fpu_ready, 0);
        tick();
        flush = 1'b0; fpu_valid = 1'b0; fpu_IV = 1'b0;
        #1;
        check("t5_flush_wb_valid", wb_valid, 0);
        check("t5_flush_issue_ready", issue_ready, 1);
        check("t5_flush_fpu_ready_after", fpu_ready, 0);
        check("t5_flush_fflags", fflags, 5'b00101);

        // CSR write racing an accepted result
        csr_we = 1'b1; csr_wdata = 5'b00001;
        tick();
        csr_we = 1'b0;
        #1 check("t4_csr_set", fflags, 5'b00001);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        csr_we = 1'b1; csr_wdata = 5'b00000;
        fpu_valid = 1'b1; fpu_y = 32'h4080_0000; fpu_DZ = 1'b1;
        expect_wb(5'd7, 32'h4080_0000);
        tick();
        csr_we = 1'b0; fpu_valid = 1'b0; fpu_DZ = 1'b0;
        #1 check("t4_csr_race", fflags, 5'b01000);
        tick();

        // Reset in the middle of a stall
        wb_ready = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        fpu_valid = 1'b1; fpu_y = 32'h0000_1234; fpu_UF = 1'b1;
        tick();
        fpu_valid = 1'b0; fpu_UF = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        #1;
        check("t6_pre_wb_valid", wb_valid, 1);
        check("t6_pre_full", issue_ready, 0);
        check("t6_pre_fflags", fflags, 5'b01010);
        reset = 1'b1; fpu_valid = 1'b1;
        tick();
        reset = 1'b0; fpu_valid = 1'b0;
        #1;
        check("t6_wb_valid", wb_valid, 0);
        check("t6_wb_rd", wb_rd, 0);
        check("t6_wb_data", wb_data, 0);
        check("t6_fflags", fflags, 0);
        check("t6_issue_ready", issue_ready, 1);
        check("t6_fpu_ready", fpu_ready, 0);

        tick();
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
